// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous imem, feeds F/D; stall holds, redirect squashes.
// Optional j/jal steering in fetch when FETCH_JUMP_PREDICT_EN is defined; otherwise jumpPredicted is tied low.
module fetch_unit #(
  parameter int          PC_W     = 12,
  parameter logic [31:0] NOP_INST = 32'h00000000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirectPc,
  output logic [PC_W-1:0] imemAddr,
  input  logic [31:0]     imemData,
  output logic [31:0]     inst,
  output logic            instValid,
  output logic [PC_W-1:0] seqNextPc,
  output logic            fdEnable,
  output logic            jumpPredicted
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_out_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_out_pc_nxt;

`ifdef FETCH_JUMP_PREDICT_EN
  logic            w_is_jump;
  logic [PC_W-1:0] w_jump_tgt;

  assign w_is_jump  = (imemData[31:27] == 5'b00001) || (imemData[31:27] == 5'b00011);
  assign w_jump_tgt = imemData[PC_W-1:0];
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_BOOT;
      r_pc     <= '0;
      r_out_pc <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_out_pc <= w_out_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_out_pc_nxt  = r_out_pc;
    imemAddr      = r_pc;
    inst          = NOP_INST;
    instValid     = 1'b0;
    jumpPredicted = 1'b0;

    if (redirect) begin
      // Wrong-path word on imemData is squashed; target is fetched this cycle.
      imemAddr     = redirectPc;
      w_out_pc_nxt = redirectPc;
      w_pc_nxt     = redirectPc + PC_ONE;
      w_state_nxt  = S_RUN;
    end else begin
      case (r_state)
        S_BOOT: begin
          w_out_pc_nxt = r_pc;
          w_pc_nxt     = r_pc + PC_ONE;
          w_state_nxt  = S_RUN;
        end
        default: begin
          inst      = imemData;
          instValid = 1'b1;
          if (stall) begin
            // Re-read the presented word so it is still on imemData after release.
            imemAddr    = r_out_pc;
            w_state_nxt = S_HOLD;
          end
`ifdef FETCH_JUMP_PREDICT_EN
          else if (w_is_jump) begin
            imemAddr      = w_jump_tgt;
            w_out_pc_nxt  = w_jump_tgt;
            w_pc_nxt      = w_jump_tgt + PC_ONE;
            jumpPredicted = 1'b1;
            w_state_nxt   = S_RUN;
          end
`endif
          else begin
            imemAddr     = r_pc;
            w_out_pc_nxt = r_pc;
            w_pc_nxt     = r_pc + PC_ONE;
            w_state_nxt  = S_RUN;
          end
        end
      endcase
    end
  end

  assign seqNextPc = r_out_pc + PC_ONE;
  assign fdEnable  = ~stall | redirect;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: instruction-stream reference model plus a negedge monitor.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [11:0] redirectPc = 12'h000;
  logic [11:0] imemAddr;
  logic [31:0] imemData = 32'h0;
  logic [31:0] inst;
  logic        instValid;
  logic [11:0] seqNextPc;
  logic        fdEnable;
  logic        jumpPredicted;

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirectPc(redirectPc), .imemAddr(imemAddr), .imemData(imemData),
    .inst(inst), .instValid(instValid), .seqNextPc(seqNextPc),
    .fdEnable(fdEnable), .jumpPredicted(jumpPredicted)
  );

  logic [31:0] mem [0:4095];
  always @(posedge clock) imemData <= mem[imemAddr];

`ifdef FETCH_JUMP_PREDICT_EN
  localparam bit PREDICT = 1'b1;
`else
  localparam bit PREDICT = 1'b0;
`endif

  typedef struct {
    bit          chk;
    logic [31:0] inst;
    bit          vld;
    logic [11:0] addr;
    logic [11:0] seq;
    bit          fde;
    bit          jp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Model: m_cur is the address whose word F/D sees this cycle; m_valid=0 means start-up bubble.
  int   m_cur   = 0;
  bit   m_valid = 1'b0;

  function automatic bit is_jump(input logic [31:0] w);
    return (w[31:27] == 5'b00001) || (w[31:27] == 5'b00011);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
  endtask

  task automatic step(input bit rst, input bit stl, input bit rdr, input int rpc);
    exp_t e;
    int   nxt;
    bit   nv;
    reset      = rst;
    stall      = stl;
    redirect   = rdr;
    redirectPc = 12'(rpc);
    e.chk  = !rst;
    e.fde  = !stl || rdr;
    e.seq  = 12'((m_cur + 1) % 4096);
    e.inst = 32'h0;
    e.vld  = 1'b0;
    e.jp   = 1'b0;
    e.addr = 12'(m_cur);
    nxt    = m_cur;
    nv     = m_valid;
    if (rst) begin
      nxt = 0;
      nv  = 1'b0;
    end else if (rdr) begin
      e.addr = 12'(rpc);
      nxt    = rpc;
      nv     = 1'b1;
    end else if (!m_valid) begin
      nv = 1'b1;
    end else begin
      e.inst = mem[m_cur];
      e.vld  = 1'b1;
      if (!stl) begin
        if (PREDICT && is_jump(e.inst)) begin
          nxt  = int'(e.inst[11:0]);
          e.jp = 1'b1;
        end else begin
          nxt = (m_cur + 1) % 4096;
        end
        e.addr = 12'(nxt);
      end
    end
    sb.push_back(e);
    @(posedge clock);
    #1;
    m_cur   = nxt;
    m_valid = nv;
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk) begin
        chk("inst",          inst,               e.inst);
        chk("instValid",     32'(instValid),     32'(e.vld));
        chk("imemAddr",      32'(imemAddr),      32'(e.addr));
        chk("seqNextPc",     32'(seqNextPc),     32'(e.seq));
        chk("fdEnable",      32'(fdEnable),      32'(e.fde));
        chk("jumpPredicted", 32'(jumpPredicted), 32'(e.jp));
      end
    end
  end

  initial begin
    int a;
    for (int i = 0; i < 4096; i++) mem[i] = 32'(i) + 32'h100;
    for (int i = 0; i < 80; i++) begin
      a = $urandom_range(16, 4095);
      if (a != 12'h040 && a != 12'h080)
        mem[a] = {($urandom_range(0, 1) == 1) ? 5'b00001 : 5'b00011, 15'($urandom), 12'($urandom)};
    end
    mem[2] = 32'h08000080;

    @(posedge clock);
    #1;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    step(0, 0, 1, 4);
    step(0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 1, 12'h040);
    step(0, 0, 0, 0);
    step(0, 1, 1, 3);
    step(0, 0, 0, 0);
    step(0, 0, 1, 12'hFFF);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 9);
    step(1, 0, 1, 9);
    repeat (3) step(0, 0, 0, 0);

    for (int c = 0; c < 3000; c++) begin
      int rpc;
      case ($urandom_range(0, 3))
        0:       rpc = 4095;
        1:       rpc = 4094;
        default: rpc = $urandom_range(0, 4095);
      endcase
      step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 10, rpc);
    end

    reset = 1'b0; stall = 1'b0; redirect = 1'b0;
    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
